// File: rtl/adder_fu_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_fu_if
// Brief    : Dispatch and CDB handshake bundle for the adder functional unit.
// Revision : 1.0
// ============================================================================
interface adder_fu_if #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
);
    logic              disp_valid;
    logic              disp_ready;
    logic [TAG_W-1:0]  disp_tag;
    logic              disp_op;
    logic [DATA_W-1:0] disp_vj;
    logic [DATA_W-1:0] disp_vk;
    logic              cdb_req;
    logic              cdb_grant;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic              cdb_ovf;
    logic              busy;

    // Reservation stations and CDB arbiter side
    modport master (
        output disp_valid, disp_tag, disp_op, disp_vj, disp_vk, cdb_grant,
        input  disp_ready, cdb_req, cdb_valid, cdb_tag, cdb_value, cdb_ovf, busy
    );

    // Functional unit side
    modport slave (
        input  disp_valid, disp_tag, disp_op, disp_vj, disp_vk, cdb_grant,
        output disp_ready, cdb_req, cdb_valid, cdb_tag, cdb_value, cdb_ovf, busy
    );
endinterface
`default_nettype wire

// File: rtl/adder_fu.sv
`default_nettype none
// ============================================================================
// Module   : adder_fu
// Brief    : Pipelined add/sub unit with a 2-entry result buffer feeding the CDB.
// Revision : 1.0
// ============================================================================
module adder_fu #(
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 3,
    parameter int LATENCY = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    adder_fu_if.slave bus
);
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
        logic              ovf;
    } entry_t;

    logic [LATENCY-1:0] stg_v_q, stg_v_d;
    entry_t [LATENCY-1:0] stg_q, stg_d;
    entry_t [1:0]       fifo_q, fifo_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               cdb_valid_q, cdb_valid_d;
    entry_t             cdb_q, cdb_d;

    logic [DATA_W-1:0]  w_result;
    logic               w_ovf;
    entry_t             w_new;
    logic               w_last_v;
    logic               w_req;
    logic               w_pop;
    logic               w_full;
    logic               w_stall;
    logic               w_push;
    logic               w_accept;

    assign w_result = bus.disp_op ? (bus.disp_vj - bus.disp_vk) : (bus.disp_vj + bus.disp_vk);

    // Sub overflows when signs differ, add when they match; both need result sign != Vj sign
    assign w_ovf = (bus.disp_op ? (bus.disp_vj[DATA_W-1] != bus.disp_vk[DATA_W-1])
                                : (bus.disp_vj[DATA_W-1] == bus.disp_vk[DATA_W-1]))
                   && (w_result[DATA_W-1] != bus.disp_vj[DATA_W-1]);

    always_comb begin
        w_new       = '0;
        w_new.tag   = bus.disp_tag;
        w_new.value = w_result;
        w_new.ovf   = w_ovf;
    end

    assign w_last_v = stg_v_q[LATENCY-1];
    assign w_req    = (count_q != 2'd0);
    assign w_pop    = w_req && bus.cdb_grant;
    assign w_full   = (count_q == 2'd2);
    assign w_stall  = w_last_v && w_full && !w_pop;
    assign w_push   = w_last_v && !w_stall;
    assign w_accept = bus.disp_valid && !w_stall;

    // Global stall: every stage holds together, bubbles are never squeezed out
    always_comb begin
        stg_v_d = stg_v_q;
        stg_d   = stg_q;
        if (!w_stall) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                stg_v_d[i] = stg_v_q[i-1];
                stg_d[i]   = stg_q[i-1];
            end
            stg_v_d[0] = w_accept;
            stg_d[0]   = w_new;
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            fifo_d[wr_ptr_q] = stg_q[LATENCY-1];
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (w_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
    end

    always_comb begin
        cdb_valid_d = w_pop;
        cdb_d       = w_pop ? fifo_q[rd_ptr_q] : cdb_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_v_q     <= '0;
            stg_q       <= '0;
            fifo_q      <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            cdb_valid_q <= 1'b0;
            cdb_q       <= '0;
        end else begin
            stg_v_q     <= stg_v_d;
            stg_q       <= stg_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_q       <= cdb_d;
        end
    end

    assign bus.disp_ready = !w_stall;
    assign bus.cdb_req    = w_req;
    assign bus.cdb_valid  = cdb_valid_q;
    assign bus.cdb_tag    = cdb_q.tag;
    assign bus.cdb_value  = cdb_q.value;
    assign bus.cdb_ovf    = cdb_q.ovf;
    assign bus.busy       = (|stg_v_q) || w_req;
endmodule
`default_nettype wire

// File: doc/adder_fu.md
# adder_fu

Pipelined add/subtract functional unit for the Tomasulo datapath. It sits directly downstream of the adder reservation stations. It accepts a ready operation (tag, Vj, Vk, op) from whichever station dispatches, and computes the 16-bit result over a fixed pipeline. It buffers completed results until the CDB arbiter grants the bus, then broadcasts tag + value for one cycle so stations and the register file can capture it.

## Interface
- DATA_W, 16, operand/result width (matches CDB)
- TAG_W, 3, reservation-station tag width
- LATENCY, 2, pipeline stages from dispatch to result buffer; legal 1..4
- Clock  in  1  single clock, all state on posedge
- Resetn  in  1  asynchronous, active-low reset
- disp_valid  in  1  station presents an operation
- disp_ready  out  1  unit accepts this cycle (combinational)
- disp_tag  in  TAG_W  producing station tag
- disp_op  in  1  0 = Vj+Vk, 1 = Vj−Vk
- disp_vj, disp_vk  in  DATA_W  operand values
- cdb_req  out  1  result buffer non-empty
- cdb_grant  in  1  arbiter grant for this cycle
- cdb_valid  out  1  broadcast strobe, one cycle per result
- cdb_tag  out  TAG_W  tag of broadcast result
- cdb_value  out  DATA_W  broadcast result
- cdb_ovf  out  1  signed overflow of broadcast result
- busy  out  1  any pipeline stage or buffer entry valid

## Operation
- Result is computed combinationally at dispatch and carried through stages s1..sLATENCY with {valid, tag, value, ovf}.
- Arithmetic is modulo 2^DATA_W.
- ovf is set on add when the operands have equal signs and the result sign differs. On sub, it is set when the operand signs differ and the result sign differs from Vj.
- Result buffer: 2-entry FIFO with in-order pop.
- Push when sLATENCY is valid and the pipeline advances.
- Pop when cdb_req && cdb_grant at the clock edge.
- Stall = sLATENCY valid && FIFO full && no pop this edge. Stall freezes all stages (global stall, no bubble collapse).
- disp_ready = !stall. A dispatch is accepted on any edge with disp_valid && disp_ready.
- With no dispatch, an advancing pipeline shifts a bubble (valid=0) into s1.
- Simultaneous push and pop at full is legal; occupancy stays 2 and no stall occurs.
- Grant with cdb_req low is ignored; no pop and no strobe.
- On pop: cdb_valid, cdb_tag, cdb_value and cdb_ovf register the head entry. cdb_valid is high for exactly the following cycle. If there is no pop, cdb_valid = 0 and tag/value/ovf hold their last value.
- Reset (any time, including mid-pipeline or mid-broadcast):
  - All stage valids and FIFO pointers/count clear.
  - cdb_valid = 0, cdb_tag = 0, cdb_value = 0, cdb_ovf = 0.
  - cdb_req = 0, busy = 0, disp_ready = 1.
  - In-flight operations are discarded.

## Timing
- Dispatch accepted at edge E enters s1 at E and reaches sLATENCY at E+LATENCY−1, with no stalls.
- It is pushed to the FIFO at E+LATENCY; cdb_req rises after E+LATENCY.
- With grant held high, the pop occurs at E+LATENCY+1, and cdb_valid is high in the cycle after that edge.
- Dispatch-to-broadcast latency is LATENCY+1 edges.
- Throughput is one op per cycle while grants keep pace.
- disp_ready and cdb_req are combinational from registered state plus cdb_grant.
- No combinational path from disp_valid to any output.

## Test plan
- Reset, LATENCY=2, grant tied high. Dispatch tag=3, add 0x0005+0x0007 at edge 0 -> cdb_valid high exactly one cycle after edge 3 with tag=3, value=0x000C, ovf=0.
- Dispatch sub 0x8000−0x0001 (tag 1), then add 0x7FFF+0x0001 (tag 2) back-to-back -> broadcasts in consecutive cycles: 0x7FFF ovf=1, then 0x8000 ovf=1. Add 0xFFFF+0x0001 -> 0x0000, ovf=0.
- Grant held low, dispatch 5 ops back-to-back with tags 0..4:
  - cdb_req rises.
  - FIFO fills to 2, pipeline fills, then disp_ready drops.
  - Exactly 4 ops accepted (2 buffered + 2 in stages).
  - Raise grant -> broadcasts in tag order 0,1,2,3, each one cycle wide, and disp_ready returns.
- FIFO full and sLATENCY valid with grant high on the same edge -> push and pop both happen, disp_ready stays 1, no op lost or duplicated (check tag sequence).
- Pulse Resetn low asynchronously between clock edges while 3 ops are in flight and cdb_valid=1:
  - Outputs clear immediately: cdb_valid=0, cdb_value=0, cdb_req=0, busy=0.
  - No broadcast of pre-reset tags after release.
- Grant pulsed while cdb_req=0 -> no cdb_valid, FIFO state unchanged.
